// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with an oversampled phase counter, a two-flop input synchronizer and framing-error detection.
//   Parameter OVERSAMPLE: CLK_RX cycles per bit (even, >= 4).
//   Ports: CLK_RX receive clock, RST async active-low reset, RX serial line (idle high),
//          DATA last good byte, VALID one-cycle good-byte strobe, FERR one-cycle framing-error strobe.
//   Optional build macro SERIAL_RX_MAJORITY_EN: the bit sample is a 3-sample majority vote instead of a single sample.
module serial_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK_RX,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR
);
  localparam int H = OVERSAMPLE / 2;
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_START = PW'(H - 1);
  localparam logic [PW-1:0] PH_BIT = PW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic [1:0] sync_q, sync_d;
  logic rx_s, sample;
  assign rx_s = sync_q[1];
`ifdef SERIAL_RX_MAJORITY_EN
  // the two previous rx_s values plus the current one form the voting window
  logic [1:0] hist_q, hist_d;
  always_comb hist_d = {hist_q[0], rx_s};
  always_ff @(posedge CLK_RX or negedge RST)
    if (!RST) hist_q <= 2'b11;
    else hist_q <= hist_d;
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif
  always_comb begin
    sync_d = {sync_q[0], RX};
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        state_d = rx_s ? S_IDLE : S_START;
      end
      S_START: if (phase_q == PH_START) begin
        phase_d = '0;
        bitcnt_d = '0;
        state_d = sample ? S_IDLE : S_DATA;
      end
      S_DATA: if (phase_q == PH_BIT) begin
        phase_d = '0;
        shift_d = {sample, shift_q[7:1]};
        bitcnt_d = bitcnt_q + 1'b1;
        state_d = (bitcnt_q == 3'd7) ? S_STOP : S_DATA;
      end
      // leaving at mid-stop lets a start bit that follows immediately be caught
      S_STOP: if (phase_q == PH_BIT) begin
        valid_d = sample;
        ferr_d = !sample;
        data_d = sample ? shift_q : data_q;
        state_d = sample ? S_IDLE : S_BREAK;
      end
      // a held-low line must return high before another start can be seen
      S_BREAK: state_d = rx_s ? S_IDLE : S_BREAK;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK_RX or negedge RST)
    if (!RST) begin
      sync_q <= 2'b11;
      state_q <= S_IDLE;
      phase_q <= '0;
      bitcnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      phase_q <= phase_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  assign DATA = data_q;
  assign VALID = valid_q;
  assign FERR = ferr_q;
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized self-checking bench for serial_rx against a frame-level timing/data model.
module tb_serial_rx;
  localparam int OS = 16;
  localparam int LAT = 3 + OS / 2 + 9 * OS;
  logic clk = 0, rst_n = 0, rx = 1;
  logic [7:0] data;
  logic valid, ferr;
  int cyc = 0, checks = 0, errors = 0, viol = 0;
  int v_cyc[$], f_cyc[$], exp_c[$];
  logic [7:0] v_dat[$], exp_d[$];
  logic prev_v = 0, prev_f = 0;
  serial_rx #(.OVERSAMPLE(OS)) dut (
    .CLK_RX(clk), .RST(rst_n), .RX(rx), .DATA(data), .VALID(valid), .FERR(ferr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data);
    end
    if (ferr) f_cyc.push_back(cyc);
    if ((valid && ferr) || (valid && prev_v) || (ferr && prev_f)) viol++;
    prev_v = valid;
    prev_f = ferr;
  end
  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx = v;
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch, input int ncyc, output int n);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) n = cyc;
      rx = fr[i / OS] ^ (i == glitch);
    end
  endtask
  task automatic clear_q();
    v_cyc.delete(); v_dat.delete(); f_cyc.delete(); exp_c.delete(); exp_d.delete();
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
    rst_n = 1;
    idle(30, 1);
    checks++; if (v_cyc.size() + f_cyc.size() !== 0) begin errors++; $display("FAIL reset_idle_events got %0d want 0", v_cyc.size() + f_cyc.size()); end
  endtask
  task automatic test_random_bytes();
    int n;
    logic [7:0] b;
    clear_q();
    for (int k = 0; k < 8; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      idle($urandom_range(0, 20), 1);
      send_frame(b, 1, -1, 10 * OS, n);
      exp_c.push_back(n + LAT);
      exp_d.push_back(b);
    end
    idle(20, 1);
    checks++; if (v_cyc.size() !== exp_c.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", v_cyc.size(), exp_c.size()); end
    for (int k = 0; k < exp_c.size() && k < v_cyc.size(); k++) begin
      checks++; if (v_dat[k] !== exp_d[k] || v_cyc[k] !== exp_c[k]) begin errors++; $display("FAIL rand_byte%0d got %h@%0d want %h@%0d", k, v_dat[k], v_cyc[k], exp_d[k], exp_c[k]); end
    end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL rand_ferr got %0d want 0", f_cyc.size()); end
  endtask
  task automatic test_false_start();
    int n;
    clear_q();
    idle(4, 0);
    idle(30, 1);
    checks++; if (v_cyc.size() + f_cyc.size() !== 0) begin errors++; $display("FAIL false_start_events got %0d want 0", v_cyc.size() + f_cyc.size()); end
    send_frame(8'h3C, 1, -1, 10 * OS, n);
    idle(20, 1);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL false_start_count got %0d want 1", v_cyc.size()); end
    else begin
      checks++; if (v_dat[0] !== 8'h3C || v_cyc[0] !== n + LAT) begin errors++; $display("FAIL false_start_byte got %h@%0d want 3c@%0d", v_dat[0], v_cyc[0], n + LAT); end
    end
  endtask
  task automatic test_framing_error();
    int n, n2;
    logic [7:0] prev;
    prev = 8'($urandom) | 8'h01;
    send_frame(prev, 1, -1, 10 * OS, n);
    idle(10, 1);
    clear_q();
    send_frame(8'h55, 0, -1, 10 * OS, n);
    idle(40, 0);
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", f_cyc.size()); end
    else begin
      checks++; if (f_cyc[0] !== n + LAT) begin errors++; $display("FAIL ferr_cycle got %0d want %0d", f_cyc[0], n + LAT); end
    end
    checks++; if (data !== prev) begin errors++; $display("FAIL ferr_data_hold got %h want %h", data, prev); end
    checks++; if (v_cyc.size() !== 0) begin errors++; $display("FAIL ferr_no_valid got %0d want 0", v_cyc.size()); end
    idle(20, 1);
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL break_no_restart got %0d want 1", f_cyc.size()); end
    send_frame(8'h81, 1, -1, 10 * OS, n2);
    idle(20, 1);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL after_ferr_count got %0d want 1", v_cyc.size()); end
    else begin
      checks++; if (v_dat[0] !== 8'h81 || v_cyc[0] !== n2 + LAT) begin errors++; $display("FAIL after_ferr_byte got %h@%0d want 81@%0d", v_dat[0], v_cyc[0], n2 + LAT); end
    end
  endtask
  task automatic test_back_to_back();
    int n1, n2;
    clear_q();
    send_frame(8'h00, 1, -1, 10 * OS, n1);
    send_frame(8'hFF, 1, -1, 10 * OS, n2);
    idle(20, 1);
    checks++; if (v_cyc.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", v_cyc.size()); end
    else begin
      checks++; if (v_dat[0] !== 8'h00 || v_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data got %h,%h want 00,ff", v_dat[0], v_dat[1]); end
      checks++; if (v_cyc[1] - v_cyc[0] !== 10 * OS) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", v_cyc[1] - v_cyc[0], 10 * OS); end
    end
  endtask
  task automatic test_reset_mid();
    int n;
    send_frame(8'hC3, 1, -1, 6 * OS - 8, n);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    checks++; if (data !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL midreset_outputs got %h/%b/%b want 00/0/0", data, valid, ferr); end
    @(posedge clk);
    #1 rst_n = 1;
    rx = 1;
    clear_q();
    idle(20, 1);
    send_frame(8'h5A, 1, -1, 10 * OS, n);
    idle(20, 1);
    checks++; if (v_cyc.size() !== 1 || f_cyc.size() !== 0) begin errors++; $display("FAIL midreset_events got %0d/%0d want 1/0", v_cyc.size(), f_cyc.size()); end
    else begin
      checks++; if (v_dat[0] !== 8'h5A || v_cyc[0] !== n + LAT) begin errors++; $display("FAIL midreset_byte got %h@%0d want 5a@%0d", v_dat[0], v_cyc[0], n + LAT); end
    end
  endtask
  task automatic test_majority();
    int n;
    logic [7:0] want;
`ifdef SERIAL_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    clear_q();
    send_frame(8'h00, 1, 3 + OS / 2 + 4 * OS - 3, 10 * OS, n);
    idle(20, 1);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL glitch_count got %0d want 1", v_cyc.size()); end
    else begin
      checks++; if (v_dat[0] !== want) begin errors++; $display("FAIL glitch_data got %h want %h", v_dat[0], want); end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules got %0d violations want 0", viol); end
  endtask
  initial begin
    test_reset();
    test_random_bytes();
    test_false_start();
    test_framing_error();
    test_back_to_back();
    test_reset_mid();
    test_majority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_rx.md
# serial_rx

UART receiver pairing with the team's serial transmitter: recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from an asynchronous serial line using an oversampling clock. It sits between the board RX pin and the byte-consuming logic. Each good byte is delivered with a one-cycle strobe, and each bad stop bit is flagged.

## Interface
Parameters:
- OVERSAMPLE, default 16: CLK_RX cycles per bit. Must be even and ≥ 4. Let H = OVERSAMPLE/2.

Ports:
- CLK_RX  in  1  receive clock at OVERSAMPLE × baud.
- RST  in  1  reset; one clock; reset is asynchronous and active-low.
- RX  in  1  serial line, idle high, asynchronous to CLK_RX.
- DATA  out  8  last correctly received byte. Holds its value until the next good frame.
- VALID  out  1  one-cycle pulse; DATA is updated in the same cycle.
- FERR  out  1  one-cycle pulse on framing error (stop bit sampled low).

## Operation
- RX passes through a two-flop synchronizer; the result is rx_s. Both flops reset to 1.
- Phase counter: $clog2(OVERSAMPLE) bits. Bit counter: 3 bits. Shift register: 8 bits.
- IDLE: if rx_s == 0, go to START and set phase = 0.
- START: phase increments each cycle. When phase == H−1, evaluate the sample:
  - sample 0 → go to DATA, phase = 0, bitcnt = 0.
  - sample 1 → false start; return to IDLE.
- DATA: phase increments each cycle. When phase == OVERSAMPLE−1:
  - shift = {sample, shift[7:1]}; phase = 0.
  - after the 8th bit (bitcnt == 7), go to STOP; otherwise bitcnt++.
- STOP: when phase == OVERSAMPLE−1, evaluate the sample:
  - sample 1 → DATA = shift, VALID = 1, go to IDLE.
  - sample 0 → FERR = 1, DATA unchanged, go to BREAK.
- BREAK: wait for rx_s == 1, then go to IDLE. This blocks false start detection on a held-low line.
- "sample" is defined under Configuration.
- VALID and FERR are registered. They are never high together and never high for two consecutive cycles.
- Async reset (any state, mid-frame included) forces:
  - state IDLE; phase, bitcnt and shift = 0;
  - DATA = 8'h00, VALID = 0, FERR = 0;
  - synchronizer flops = 1.

## Timing
- Let E0 be the clock edge on which IDLE sees rx_s == 0. E0 is 2 edges after the RX falling edge is captured.
- Start bit is evaluated at E0+H.
- Data bit k (k = 0..7) is evaluated at E0+H+(k+1)·OVERSAMPLE.
- Stop bit is evaluated at E0+H+9·OVERSAMPLE. VALID or FERR is high for the cycle following that edge.
- Sampling lands at mid-bit, ±1 CLK_RX cycle of synchronizer skew.
- Return to IDLE happens at mid-stop, so a start bit immediately following the stop bit is detected. Back-to-back frames need no gap.
- Glitches shorter than H cycles on an idle line are rejected as false starts.

## Configuration
- SERIAL_RX_MAJORITY_EN defined:
  - a 3-bit history of rx_s is kept;
  - sample = majority vote of rx_s values at phases (decision−2, decision−1, decision), where the decision phase is H−1 or OVERSAMPLE−1;
  - a single-cycle glitch inside that window is rejected;
  - timing is unchanged.
- Not defined: sample = rx_s at the decision phase only.
- OVERSAMPLE ≥ 4 guarantees the window stays within the bit in both builds.

## Test plan
- Good byte, OVERSAMPLE=16: send 8'hA5 at 1 bit / 16 clocks → exactly one VALID pulse, DATA=8'hA5, VALID rising at E0+8+144+1; FERR stays 0.
- False start: 4-cycle low pulse on an idle line → no VALID, no FERR; state back in IDLE; a following 8'h3C frame is received correctly.
- Framing error: 8'h55 with stop bit low, line held low for 40 cycles and then high → one FERR pulse; DATA keeps its prior value; no start detected while low; next frame 8'h81 gives VALID with DATA=8'h81.
- Back-to-back: 8'h00 then 8'hFF with no idle gap → two VALID pulses exactly 160 cycles apart, with DATA 8'h00 then 8'hFF.
- Reset mid-frame: assert RST low during bit 4 of 8'hC3 → DATA=0, VALID=0, FERR=0 immediately (asynchronous); after release, a fresh 8'h5A frame is received correctly.
- Majority filter: 1-cycle inverted glitch at the decision phase of bit 3 in 8'h00 → with SERIAL_RX_MAJORITY_EN, DATA=8'h00; without it, DATA=8'h08.
